// File: rtl/osc_tick_gen.sv
// Multi-channel programmable tick/toggle generator on a single system clock.
// Each channel down-counts from its divide value and strobes tick_o on reaching zero.
module osc_tick_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 3,
    parameter int ADDR_W      = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              osc_en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIV_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DIV_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] tog_o
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    // The value loaded into cnt at each reload is the channel's active divide, so the
    // counter itself carries it; a running period never sees a later shadow write.
    logic [DIV_W-1:0]  shadow_q [NUM_CH];
    logic [DIV_W-1:0]  shadow_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] tog_q, tog_d;
    logic [DIV_W-1:0]  rd_data_q, rd_data_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            cnt_d[i]    = cnt_q[i];
            tick_d[i]   = 1'b0;
            tog_d[i]    = tog_q[i];

            // Out-of-range write addresses never match any channel index.
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                shadow_d[i] = wr_data;
            end

            if (osc_en) begin
                if (!ch_en[i]) begin
                    cnt_d[i] = '0;
                end else if (sync_i || (cnt_q[i] == '0)) begin
                    tick_d[i] = 1'b1;
                    tog_d[i]  = ~tog_q[i];
                    cnt_d[i]  = shadow_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - DIV_W'(1);
                end
            end
        end

        rd_data_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= DEF_DIV;
                cnt_q[i]    <= '0;
            end
            tick_q    <= '0;
            tog_q     <= '0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            tick_q    <= tick_d;
            tog_q     <= tog_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign tick_o  = tick_q;
    assign tog_o   = tog_q;

endmodule

// File: tb/tb_osc_tick_gen.sv
// Directed bench for osc_tick_gen: cycle-by-cycle expected tick/toggle/readback values.
module tb_osc_tick_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        osc_en;
    logic [3:0]  ch_en;
    logic        sync_i;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  tick_o;
    logic [3:0]  tog_o;

    int checks   = 0;
    int failures = 0;

    osc_tick_gen #(
        .NUM_CH     (4),
        .DIV_W      (16),
        .DEFAULT_DIV(3),
        .ADDR_W     (4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .osc_en (osc_en),
        .ch_en  (ch_en),
        .sync_i (sync_i),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .tick_o (tick_o),
        .tog_o  (tog_o)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst = 1'b1; osc_en = 1'b0; ch_en = 4'h0; sync_i = 1'b0;
        wr_en = 1'b0; wr_addr = 4'h0; wr_data = 16'h0; rd_addr = 4'h0;
        step();
        step();
        chk("reset_tick", 32'(tick_o), 32'h0);
        chk("reset_tog", 32'(tog_o), 32'h0);
        chk("reset_rd", 32'(rd_data), 32'h0);

        // All channels at default N=3: ticks at cycles 1,5,9, toggle period 8.
        sys_rst = 1'b0; osc_en = 1'b1; ch_en = 4'hF;
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("t1_tick_c%0d", c), 32'(tick_o), (c % 4 == 1) ? 32'hF : 32'h0);
            chk($sformatf("t1_tog_c%0d", c), 32'(tog_o), (((c - 1) / 4) % 2 == 0) ? 32'hF : 32'h0);
        end

        // Cycle 9: write N=0 to ch1 mid-period; it completes, then ticks every cycle.
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'd0;
        for (int c = 10; c <= 16; c++) begin
            step();
            wr_en = 1'b0;
            chk($sformatf("t2_tick1_c%0d", c), 32'(tick_o[1]), (c >= 13) ? 32'h1 : 32'h0);
            chk($sformatf("t2_tick0_c%0d", c), 32'(tick_o[0]), (c == 13) ? 32'h1 : 32'h0);
        end

        // Out-of-range write is ignored and out-of-range read returns 0.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'd9; rd_addr = 4'd7;
        step();
        chk("t3_rd_oor", 32'(rd_data), 32'h0);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'd3; rd_addr = 4'd1;
        step();
        chk("t3_rd_same_edge", 32'(rd_data), 32'h0);
        wr_en = 1'b0;
        step();
        chk("t3_rd_after_wr", 32'(rd_data), 32'h3);
        for (int k = 0; k < 4; k++) begin
            rd_addr = 4'(k);
            step();
            chk($sformatf("t3_rd_ch%0d", k), 32'(rd_data), 32'h3);
        end

        // Phase alignment: ch0 N=3 and ch2 N=5 started at different cycles, then sync.
        sys_rst = 1'b1;
        step();
        chk("t4_reset_tick", 32'(tick_o), 32'h0);
        sys_rst = 1'b0; osc_en = 1'b1; ch_en = 4'h0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'd5;
        step();
        wr_en = 1'b0; ch_en = 4'b0001;
        step();
        chk("t4_c1", 32'(tick_o), 32'h1);
        step();
        chk("t4_c2", 32'(tick_o), 32'h0);
        ch_en = 4'b0101;
        step();
        chk("t4_c3", 32'(tick_o), 32'h4);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        chk("t4_sync_c4", 32'(tick_o), 32'h5);
        for (int c = 5; c <= 16; c++) begin
            logic [3:0] exp_t;
            step();
            exp_t = 4'h0;
            exp_t[0] = ((c - 4) % 4 == 0);
            exp_t[2] = ((c - 4) % 6 == 0);
            chk($sformatf("t4_tick_c%0d", c), 32'(tick_o), 32'(exp_t));
        end

        // Freeze: ch0 cnt=2, ch2 cnt=4 at cycle 17; 10 frozen edges, then resume.
        step();
        chk("t5_c17_tick", 32'(tick_o), 32'h0);
        chk("t5_c17_tog", 32'(tog_o), 32'h1);
        osc_en = 1'b0;
        for (int c = 18; c <= 27; c++) begin
            step();
            chk($sformatf("t5_frz_tick_c%0d", c), 32'(tick_o), 32'h0);
            chk($sformatf("t5_frz_tog_c%0d", c), 32'(tog_o), 32'h1);
        end
        osc_en = 1'b1;
        for (int c = 28; c <= 32; c++) begin
            step();
            chk($sformatf("t5_res_tick_c%0d", c), 32'(tick_o),
                (c == 30) ? 32'h1 : (c == 32) ? 32'h4 : 32'h0);
        end
        chk("t5_c32_tog", 32'(tog_o), 32'h4);

        // Shadow=20 on ch0, reset mid-count clears outputs and restores defaults.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'd20;
        step();
        wr_en = 1'b0; rd_addr = 4'd0;
        step();
        chk("t6_c34_tick", 32'(tick_o), 32'h1);
        chk("t6_c34_rd", 32'(rd_data), 32'd20);
        step();
        chk("t6_c35_tick", 32'(tick_o), 32'h0);
        sys_rst = 1'b1;
        step();
        chk("t6_rst_tick", 32'(tick_o), 32'h0);
        chk("t6_rst_tog", 32'(tog_o), 32'h0);
        chk("t6_rst_rd", 32'(rd_data), 32'h0);
        sys_rst = 1'b0; osc_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd_addr = 4'(k);
            step();
            chk($sformatf("t6_rd_ch%0d", k), 32'(rd_data), 32'h3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
